uart_tx_byte: RTL

- Serial transmitter that sits directly downstream of the 32x32 average-resize stage.
- Consumes that stage's 8-bit byte and transmit request (`trmt`). Returns a one-cycle `tx_done` per byte so the resize stage can advance its 0..1023 send counter.
- Drives the board UART TXD pin, 8N1, LSB first, at a fixed baud rate set by a clock divider.

---
 rtl/uart_tx_byte_if.sv | 25 ++
 rtl/uart_tx_byte.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte_if.sv
// uart_tx_byte_if: byte handshake and serial-line bundle between the resize
// stage (master) and the UART byte transmitter (slave).
interface uart_tx_byte_if;
  logic [7:0] tx_data;
  logic       trmt;
  logic       TX;
  logic       tx_done;
  logic       busy;

  modport master (
    output tx_data,
    output trmt,
    input  TX,
    input  tx_done,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  trmt,
    output TX,
    output tx_done,
    output busy
  );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 UART transmitter, LSB first, one byte per rising edge of
// trmt. It answers every completed byte with a single-cycle tx_done pulse.
// Optional even parity bit (8E1) is enabled by defining UART_PARITY_EN.
module uart_tx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_byte_if.slave  bus
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             trmt_q;
  logic             tx_q, tx_d;
  logic             txDone_q, txDone_d;
  logic             busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic accept;
  logic bitEnd;

  // A held trmt level must not restart a byte, so only a fresh 0->1 edge seen
  // while idle starts a frame; edges during a frame are simply dropped.
  assign accept = (state_q == IDLE) && bus.trmt && !trmt_q;
  assign bitEnd = (cnt_q == CNT_LAST);

  assign bus.TX      = tx_q;
  assign bus.tx_done = txDone_q;
  assign bus.busy    = busy_q;

  // State register; reset also kills any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      trmt_q   <= 1'b0;
      tx_q     <= 1'b1;
      txDone_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      trmt_q   <= bus.trmt;
      tx_q     <= tx_d;
      txDone_q <= txDone_d;
      busy_q   <= busy_d;
`ifdef UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic; TX is registered, so each bit value is loaded on the
  // same edge that enters its bit period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    txDone_d = 1'b0;
    busy_d   = busy_q;
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d = bus.tx_data;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
`ifdef UART_PARITY_EN
          parity_d = ^bus.tx_data;
`endif
        end
      end

      START: begin
        if (bitEnd) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (bitEnd) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      STOP: begin
        if (bitEnd) begin
          cnt_d    = '0;
          tx_d     = 1'b1;
          txDone_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
